cart_header_loader: RTL and testbench

Boot-time configuration sequencer for the cartridge mapper. After reset it holds the mapper in reset and reads cartridge header bytes 0x0134–0x014D from external cartridge memory through a single-outstanding read handshake. It verifies the header checksum and the cartridge type, then drives the mapper's `rom_size`/`ram_size` configuration and releases its reset. If any check fails, the mapper stays in reset and an error code is reported.

---
 rtl/cart_header_loader.sv | 128 ++++++++++++
 tb/tb_cart_header_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_header_loader.sv
// Boot-time cartridge header scanner: reads 0x134..0x14D, verifies checksum and
// cartridge type, then configures the mapper and releases its reset.
module cart_header_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [20:0] mem_adr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        mbc_reset,
    output logic [2:0]  rom_size,
    output logic [1:0]  ram_size,
    output logic [7:0]  cart_type,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [20:0]     ADR_FIRST = 21'h134;
    localparam logic [20:0]     ADR_TYPE  = 21'h147;
    localparam logic [20:0]     ADR_ROM   = 21'h148;
    localparam logic [20:0]     ADR_RAM   = 21'h149;
    localparam logic [20:0]     ADR_CHK   = 21'h14D;

    typedef enum logic [2:0] {IDLE, REQ, STEP, CHECK, DONE, ERR} state_t;

    state_t        state, state_next;
    logic [20:0]   adr;
    logic [7:0]    sum;
    logic [7:0]    type_byte;
    logic [7:0]    rom_byte;
    logic [7:0]    ram_byte;
    logic [7:0]    chk_byte;
    logic [TW-1:0] tcnt;
    logic [1:0]    code;
    logic          timed_out;
    logic          sum_ok;
    logic          hdr_ok;

    // The edge that would make the count reach TIMEOUT is the abort edge.
    assign timed_out = (tcnt == T_LAST);
    assign sum_ok    = (sum == chk_byte);
    assign hdr_ok    = (type_byte <= 8'h03) && (rom_byte <= 8'h06) &&
                       (ram_byte == 8'h00 || ram_byte == 8'h02 || ram_byte == 8'h03);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = REQ;
            REQ: begin
                if (mem_ack)        state_next = STEP;
                else if (timed_out) state_next = ERR;
            end
            STEP:  state_next = (adr == ADR_CHK) ? CHECK : REQ;
            CHECK: state_next = (sum_ok && hdr_ok) ? DONE : ERR;
            DONE:  state_next = DONE;
            ERR:   state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adr       <= '0;
            sum       <= '0;
            type_byte <= '0;
            rom_byte  <= '0;
            ram_byte  <= '0;
            chk_byte  <= '0;
            tcnt      <= '0;
            code      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    adr  <= ADR_FIRST;
                    sum  <= '0;
                    tcnt <= '0;
                end
                REQ: begin
                    if (mem_ack) begin
                        if (adr == ADR_CHK) chk_byte <= mem_data;
                        else                sum      <= sum - mem_data - 8'd1;
                        if (adr == ADR_TYPE) type_byte <= mem_data;
                        if (adr == ADR_ROM)  rom_byte  <= mem_data;
                        if (adr == ADR_RAM)  ram_byte  <= mem_data;
                    end else if (timed_out) begin
                        code <= 2'd1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                STEP: begin
                    tcnt <= '0;
                    if (adr != ADR_CHK) adr <= adr + 21'd1;
                end
                CHECK: begin
                    if (!sum_ok)      code <= 2'd2;
                    else if (!hdr_ok) code <= 2'd3;
                end
                default: ;
            endcase
        end
    end

    // Configuration outputs are gated by DONE so they switch with done itself.
    assign mem_req   = (state == REQ);
    assign mem_adr   = adr;
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign mbc_reset = ~done;
    assign err_code  = code;
    assign rom_size  = done ? rom_byte[2:0] : 3'd0;
    assign ram_size  = done ? ram_byte[1:0] : 2'd0;
    assign cart_type = done ? type_byte     : 8'd0;

endmodule

// File: tb/tb_cart_header_loader.sv
// Directed bench for cart_header_loader: header memory responder with selectable
// ack behaviour, plus a request monitor for ordering, stability and gap checks.
module tb_cart_header_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [20:0] mem_adr;
    logic        mem_ack = 1'b1;
    logic [7:0]  mem_data = 8'h00;
    logic        mbc_reset;
    logic [2:0]  rom_size;
    logic [1:0]  ram_size;
    logic [7:0]  cart_type;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    // Responder / monitor controls and observations.
    int          ack_mode = 0;   // 0 tied high, 1 random latency, 2 stall on stall_adr
    logic [20:0] stall_adr = 21'h140;
    int          stall_n = 0;    // 0: never ack stall_adr; n: ack on n-th edge
    logic [7:0]  hdr [0:25];
    int          req_count, order_bad, stable_bad, gap_bad, low_cnt, wait_cnt, lat;
    logic        in_req;
    logic [20:0] cur_adr, exp_adr;

    cart_header_loader #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_adr   (mem_adr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .mbc_reset (mbc_reset),
        .rom_size  (rom_size),
        .ram_size  (ram_size),
        .cart_type (cart_type),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hdr_byte(input logic [20:0] a);
        if (a >= 21'h134 && a <= 21'h14D) return hdr[a - 21'h134];
        return 8'hFF;
    endfunction

    // Responder and monitor run on the falling edge, away from the DUT edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_req = 1'b0; req_count = 0; exp_adr = 21'h134; order_bad = 0;
                stable_bad = 0; gap_bad = 0; low_cnt = 0; wait_cnt = 0;
                mem_ack = (ack_mode == 0);
            end else if (mem_req) begin
                if (!in_req) begin
                    if (req_count > 0 && low_cnt != 1) gap_bad++;
                    if (mem_adr != exp_adr) order_bad++;
                    exp_adr = exp_adr + 21'd1;
                    req_count++;
                    in_req = 1'b1; cur_adr = mem_adr; wait_cnt = 0; low_cnt = 0;
                    lat = (ack_mode == 1) ? int'($urandom_range(10, 0)) : 0;
                end else begin
                    if (mem_adr != cur_adr) stable_bad++;
                    wait_cnt++;
                end
                mem_data = hdr_byte(mem_adr);
                if (ack_mode == 2 && mem_adr == stall_adr)
                    mem_ack = (stall_n != 0) && (wait_cnt == stall_n - 1);
                else
                    mem_ack = (wait_cnt >= lat);
            end else begin
                in_req = 1'b0;
                low_cnt++;
                mem_ack = (ack_mode == 0);
            end
        end
    end

    // Header with filler title bytes and a checksum from the standard formula.
    task automatic build_header(input logic [7:0] t, input logic [7:0] r,
                                input logic [7:0] m, input logic [7:0] chk_delta);
        logic [7:0] s;
        for (int i = 0; i < 25; i++) hdr[i] = 8'(i * 37 + 5);
        hdr[19] = t;
        hdr[20] = r;
        hdr[21] = m;
        s = 8'h00;
        for (int i = 0; i < 25; i++) s = s - hdr[i] - 8'd1;
        hdr[25] = s + chk_delta;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        int n;
        n = 0;
        while (!(done || err) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(done || err)) begin
            errors++;
            $display("FAIL wait_end: done/err not seen within %0d cycles (done=%0b err=%0b)", bound, done, err);
        end
    endtask

    task automatic expect_good(input string tag);
        checks++;
        if ({done, err, mbc_reset, err_code} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL %s status: done=%0b err=%0b mbc_reset=%0b code=%0d, want 1 0 0 0",
                     tag, done, err, mbc_reset, err_code);
        end
        checks++;
        if ({rom_size, ram_size, cart_type} !== {3'd4, 2'd3, 8'h01}) begin
            errors++;
            $display("FAIL %s config: rom=%0d ram=%0d type=%h, want 4 3 01",
                     tag, rom_size, ram_size, cart_type);
        end
        checks++;
        if (req_count !== 26 || order_bad !== 0) begin
            errors++;
            $display("FAIL %s requests: count=%0d order_bad=%0d, want 26 0", tag, req_count, order_bad);
        end
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code);
        checks++;
        if ({done, err, mbc_reset, err_code} !== {1'b0, 1'b1, 1'b1, code}) begin
            errors++;
            $display("FAIL %s: done=%0b err=%0b mbc_reset=%0b code=%0d, want 0 1 1 %0d",
                     tag, done, err, mbc_reset, err_code, code);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_req, mem_adr, mbc_reset, done, err, err_code, rom_size, ram_size, cart_type} !==
            {1'b0, 21'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values: req=%0b adr=%h mbc_reset=%0b done=%0b err=%0b code=%0d rom=%0d ram=%0d type=%h",
                     mem_req, mem_adr, mbc_reset, done, err, err_code, rom_size, ram_size, cart_type);
        end
    endtask

    task automatic test_tied_high();
        ack_mode = 0;
        build_header(8'h01, 8'h04, 8'h03, 8'h00);
        apply_reset();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_req_early: mem_req=%0b before first edge, want 0", mem_req);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_adr !== 21'h134) begin
            errors++;
            $display("FAIL first_req: mem_req=%0b adr=%h after edge 1, want 1 134", mem_req, mem_adr);
        end
        repeat (52) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || mbc_reset !== 1'b1) begin
            errors++;
            $display("FAIL edge53: done=%0b mbc_reset=%0b, want 0 1", done, mbc_reset);
        end
        @(posedge clk); #1;
        expect_good("tied_high_edge54");
    endtask

    task automatic test_random_latency();
        ack_mode = 1;
        build_header(8'h01, 8'h04, 8'h03, 8'h00);
        apply_reset();
        wait_end(2000);
        expect_good("random_latency");
        checks++;
        if (stable_bad !== 0 || gap_bad !== 0) begin
            errors++;
            $display("FAIL handshake: stable_bad=%0d gap_bad=%0d, want 0 0", stable_bad, gap_bad);
        end
    endtask

    task automatic test_checksum_err();
        ack_mode = 0;
        build_header(8'h01, 8'h04, 8'h03, 8'h01);
        apply_reset();
        wait_end(200);
        expect_err("checksum", 2'd2);
    endtask

    task automatic test_bad_cart();
        ack_mode = 0;
        build_header(8'h05, 8'h04, 8'h03, 8'h00);
        apply_reset();
        wait_end(200);
        expect_err("bad_type", 2'd3);
        build_header(8'h01, 8'h04, 8'h01, 8'h00);
        apply_reset();
        wait_end(200);
        expect_err("bad_ram", 2'd3);
    endtask

    task automatic test_timeout();
        int n;
        ack_mode = 2; stall_adr = 21'h140; stall_n = 0;
        build_header(8'h01, 8'h04, 8'h03, 8'h00);
        apply_reset();
        n = 0;
        while (!(mem_req && mem_adr == 21'h140) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(mem_req && mem_adr == 21'h140)) begin
            errors++;
            $display("FAIL timeout_reach: request for 140 not seen, adr=%h", mem_adr);
        end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%0b mem_req=%0b at edge 15, want 0 1", err, mem_req);
        end
        @(posedge clk); #1;
        expect_err("timeout_edge16", 2'd1);
        // Ack arriving on the 16th edge must win over the abort.
        stall_n = 16;
        apply_reset();
        wait_end(400);
        expect_good("ack_on_edge16");
        ack_mode = 0; stall_n = 0;
    endtask

    task automatic test_reset_midscan();
        int n;
        ack_mode = 0;
        build_header(8'h01, 8'h04, 8'h03, 8'h00);
        apply_reset();
        n = 0;
        while (mem_adr != 21'h13E && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_req, mem_adr, done, err, mbc_reset, err_code} !== {1'b0, 21'd0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL midscan_reset: req=%0b adr=%h done=%0b err=%0b mbc_reset=%0b code=%0d",
                     mem_req, mem_adr, done, err, mbc_reset, err_code);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_adr !== 21'h134) begin
            errors++;
            $display("FAIL restart_adr: req=%0b adr=%h, want 1 134", mem_req, mem_adr);
        end
        wait_end(200);
        expect_good("after_midscan_reset");
    endtask

    initial begin
        build_header(8'h01, 8'h04, 8'h03, 8'h00);
        test_reset();
        test_tied_high();
        test_random_latency();
        test_checksum_err();
        test_bad_cart();
        test_timeout();
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
